video_timing_decoder: RTL and testbench
=======================================

VIDEO_TIMING_DECODER -- requirements
Module: video_timing_decoder

Interface
REQ-001 The block SHALL have parameter MAX_WIDTH, default 1024, meaning the largest measurable line period in enabled cycles.
REQ-002 The block SHALL have parameter MAX_HEIGHT, default 1024, meaning the largest measurable frame period in lines.
REQ-003 The block SHALL have parameter LOCK_FRAMES, default 2, meaning the number of consecutive matching frames required before lock.
REQ-004 The block SHALL have parameters col_width = $clog2(MAX_WIDTH+1) and row_width = $clog2(MAX_HEIGHT+1), meaning the counter widths.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  pixel enable; inputs are sampled only when en=1.
- vs  input  1  frame-start pulse.
- hs  input  1  line pulse.
- de  input  1  active-video level.
- skip  input  1  qualifies a de cycle as not-a-pixel.
- rgb  input  pocket::rgb_t  pixel data.
- pixel_valid  output  1  registered pixel strobe.
- pixel_x  output  col_width  x coordinate of the pixel.
- pixel_y  output  row_width  y coordinate of the pixel.
- pixel_rgb  output  pocket::rgb_t  pixel data.
- frame_start  output  1  one-cycle pulse.
- line_start  output  1  one-cycle pulse.
- total_width  output  col_width  measured line period.
- total_height  output  row_width  measured frame period.
- visible_width  output  col_width  measured active width.
- visible_height  output  row_width  measured active height.
- locked  output  1  timing is stable.
- error  output  1  one-cycle mismatch or overflow pulse.

Function
REQ-006 An accepted pixel SHALL be any clk edge with en && de && !skip; all other inputs SHALL be ignored when en=0.
REQ-007 On an accepted pixel, the block SHALL, on the next clk, assert pixel_valid for exactly one cycle with pixel_rgb=rgb and pixel_x/pixel_y equal to the current position (1-cycle latency).
REQ-008 pixel_x SHALL clear on each hs and increment after each accepted pixel, so the first pixel of a line has x=0.
REQ-009 pixel_y SHALL clear on vs and increment on each hs that follows a line containing at least one accepted pixel; the first active line SHALL be y=0.
REQ-010 The col counter SHALL count en cycles since the last hs, with the hs cycle counted as 1; the row counter SHALL count hs pulses since the last vs.
REQ-011 When vs and hs coincide, vs SHALL be processed first and that hs SHALL count as row 1.
REQ-012 On each hs, col SHALL be latched as the line period and compared with the previous line; on each vs, the frame's line period, row count, maximum accepted pixels per line and active-line count SHALL form the frame measurement.
REQ-013 frame_start and line_start SHALL pulse one clk after the vs or hs (respectively) is sampled.
REQ-014 The block SHALL implement a state machine with states SEARCH, MEASURE, VERIFY and LOCKED:
- SEARCH: on vs, go to MEASURE.
- MEASURE: on vs, publish the measurement to total_*/visible_*, clear the match count, and go to VERIFY.
- VERIFY: on vs, if the measurement equals the published values, increment the match count and go to LOCKED when it reaches LOCK_FRAMES; otherwise pulse error, publish the new values and stay in VERIFY with the count cleared.
- LOCKED: on vs with a mismatch, pulse error, deassert locked, publish the new values and go to VERIFY.
REQ-015 locked SHALL be 1 only in state LOCKED.
REQ-016 A line whose period differs from the previous line's period SHALL mark the frame as mismatched.
REQ-017 The col and row counters SHALL saturate at MAX_WIDTH and MAX_HEIGHT; saturation SHALL pulse error once and force the state to SEARCH.
REQ-018 A vs arriving mid-frame SHALL end the frame normally; the resulting short measurement SHALL be handled as a mismatch per REQ-014.
REQ-019 Published measurement outputs SHALL hold their values between updates.

Reset
REQ-020 While reset_n=0, the block SHALL be in state SEARCH and all outputs, counters and measurement registers SHALL be 0, independent of clk.
REQ-021 After reset_n deasserts, the block SHALL ignore all inputs until the first vs.

Verification
REQ-022 Scenario 1: assert reset_n=0 asynchronously mid-line -> all outputs 0 immediately; locked does not assert before 1+LOCK_FRAMES further full frames.
REQ-023 Scenario 2: 500x400 total, 400x360 visible, en=1 constant, 4 frames -> totals 500/400 and visibles 400/360 published at the 2nd vs; locked asserts at the 4th vs; pixel_x spans 0..399 and pixel_y spans 0..359; 144000 pixel_valid pulses per frame.
REQ-024 Scenario 3: same timing with en every 2nd clk and skip=1 on en=0 cycles -> identical measurements, and pixel_valid is never asserted on consecutive clks.
REQ-025 Scenario 4: after lock, one line of 499 -> error pulses at the next vs, locked drops, and locked re-asserts after LOCK_FRAMES clean frames.
REQ-026 Scenario 5: hs interval of 2000 with MAX_WIDTH=1024 -> a single error pulse, state SEARCH, locked stays 0.
REQ-027 Scenario 6: vs and hs asserted on the same cycle -> the row count starts at 1 and total_height equals the number of hs pulses per frame.

Source files
------------

// File: rtl/video_timing_decoder.sv
// Video timing decoder: recovers pixel coordinates from vs/hs/de, measures line
// and frame geometry, and reports lock once that geometry repeats frame after frame.
package pocket;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

module video_timing_decoder #(
  parameter int MAX_WIDTH   = 1024,
  parameter int MAX_HEIGHT  = 1024,
  parameter int LOCK_FRAMES = 2,
  parameter int col_width   = $clog2(MAX_WIDTH+1),
  parameter int row_width   = $clog2(MAX_HEIGHT+1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 vs,
  input  logic                 hs,
  input  logic                 de,
  input  logic                 skip,
  input  pocket::rgb_t         rgb,
  output logic                 pixel_valid,
  output logic [col_width-1:0] pixel_x,
  output logic [row_width-1:0] pixel_y,
  output pocket::rgb_t         pixel_rgb,
  output logic                 frame_start,
  output logic                 line_start,
  output logic [col_width-1:0] total_width,
  output logic [row_width-1:0] total_height,
  output logic [col_width-1:0] visible_width,
  output logic [row_width-1:0] visible_height,
  output logic                 locked,
  output logic                 error
);
  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] VERIFY  = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;
  localparam int MW = $clog2(LOCK_FRAMES+1);
  localparam logic [col_width-1:0] COL_MAX = col_width'(MAX_WIDTH);
  localparam logic [row_width-1:0] ROW_MAX = row_width'(MAX_HEIGHT);
  localparam logic [col_width-1:0] COL_ONE = col_width'(1);
  localparam logic [row_width-1:0] ROW_ONE = row_width'(1);

  logic [1:0]           state, state_n;
  logic [MW-1:0]        match_cnt, match_cnt_n;
  logic                 synced;
  logic [col_width-1:0] col, period_q, x, x_base, line_max, lmax_in;
  logic [col_width-1:0] meas_tw, meas_vw;
  logic [row_width-1:0] row, y, y_base, meas_th, meas_vh;
  logic                 line_mm, has_pix, col_sat, row_sat;
  logic                 live, vs_e, hs_e, acc, line_end;
  logic                 col_ev, row_ev, sat_ev, pchk, meas_ok, publish, mm_err;

  // Nothing is tracked until the first vs; that vs itself is processed.
  assign live     = en && (synced || vs);
  assign vs_e     = live && vs;
  assign hs_e     = live && hs;
  assign acc      = live && de && !skip;
  assign line_end = hs_e || vs_e;

  assign col_ev = live && !hs && (col == COL_MAX) && !col_sat;
  assign row_ev = hs_e && !vs && (row == ROW_MAX) && !row_sat;
  assign sat_ev = col_ev || row_ev;

  // col == 0 only before the first full line after sync: no period to latch yet.
  assign pchk    = hs_e && (col != '0) && (period_q != '0) && (col != period_q);
  assign meas_tw = (hs_e && (col != '0)) ? col : period_q;
  assign meas_th = row;
  assign lmax_in = (x > line_max) ? x : line_max;
  assign meas_vw = lmax_in;
  assign meas_vh = (has_pix && (y != ROW_MAX)) ? y + ROW_ONE : y;
  assign meas_ok = (meas_tw == total_width) && (meas_th == total_height) &&
                   (meas_vw == visible_width) && (meas_vh == visible_height) &&
                   !(line_mm || pchk);

  assign x_base = line_end ? '0 : x;
  assign y_base = vs_e ? '0 :
                  (hs_e && has_pix && (y != ROW_MAX)) ? y + ROW_ONE : y;

  assign locked = (state == LOCKED);

  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    publish     = 1'b0;
    mm_err      = 1'b0;
    if (vs_e) begin
      case (state)
        SEARCH:  state_n = MEASURE;
        MEASURE: begin
          publish     = 1'b1;
          match_cnt_n = '0;
          state_n     = VERIFY;
        end
        VERIFY: begin
          if (meas_ok) begin
            match_cnt_n = match_cnt + MW'(1);
            if (int'(match_cnt) + 1 >= LOCK_FRAMES) state_n = LOCKED;
          end else begin
            mm_err      = 1'b1;
            publish     = 1'b1;
            match_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (!meas_ok) begin
            mm_err      = 1'b1;
            publish     = 1'b1;
            match_cnt_n = '0;
            state_n     = VERIFY;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    // A saturated counter means the timing is unusable; start over.
    if (sat_ev) begin
      state_n     = SEARCH;
      match_cnt_n = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= SEARCH;
      match_cnt      <= '0;
      synced         <= 1'b0;
      col            <= '0;
      row            <= '0;
      period_q       <= '0;
      line_mm        <= 1'b0;
      col_sat        <= 1'b0;
      row_sat        <= 1'b0;
      x              <= '0;
      y              <= '0;
      has_pix        <= 1'b0;
      line_max       <= '0;
      pixel_valid    <= 1'b0;
      pixel_x        <= '0;
      pixel_y        <= '0;
      pixel_rgb      <= '0;
      frame_start    <= 1'b0;
      line_start     <= 1'b0;
      total_width    <= '0;
      total_height   <= '0;
      visible_width  <= '0;
      visible_height <= '0;
      error          <= 1'b0;
    end else begin
      state       <= state_n;
      match_cnt   <= match_cnt_n;
      error       <= sat_ev || mm_err;
      frame_start <= vs_e;
      line_start  <= hs_e;
      pixel_valid <= acc;
      if (acc) begin
        pixel_x   <= x_base;
        pixel_y   <= y_base;
        pixel_rgb <= rgb;
      end
      if (publish) begin
        total_width    <= meas_tw;
        total_height   <= meas_th;
        visible_width  <= meas_vw;
        visible_height <= meas_vh;
      end
      if (vs_e) synced <= 1'b1;
      if (live) begin
        col <= hs ? COL_ONE : (col == COL_MAX) ? col : col + COL_ONE;
        // vs is handled first, so a coincident hs opens row 1.
        if (vs)                         row <= hs ? ROW_ONE : '0;
        else if (hs && (row != ROW_MAX)) row <= row + ROW_ONE;
        if (hs && (col != '0)) period_q <= col;
        line_mm  <= !vs && (line_mm || pchk);
        col_sat  <= !hs && (col_sat || col_ev);
        row_sat  <= !vs && (row_sat || row_ev);
        x        <= (acc && (x_base != COL_MAX)) ? x_base + COL_ONE : x_base;
        y        <= y_base;
        has_pix  <= acc || (has_pix && !line_end);
        line_max <= vs ? '0 : hs ? lmax_in : line_max;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench for video_timing_decoder: 50x40 total / 40x36 visible frames,
// full and half-rate enable, line-length fault, counter saturation, height change.
module tb_video_timing_decoder;
  import pocket::*;
  localparam int CW = $clog2(1024+1);
  localparam int RW = $clog2(1024+1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0, vs = 1'b0, hs = 1'b0, de = 1'b0, skip = 1'b0;
  rgb_t          rgb;
  logic          pixel_valid, frame_start, line_start, locked, error;
  logic [CW-1:0] pixel_x, total_width, visible_width;
  logic [RW-1:0] pixel_y, total_height, visible_height;
  rgb_t          pixel_rgb;

  video_timing_decoder #(.MAX_WIDTH(1024), .MAX_HEIGHT(1024), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .vs(vs), .hs(hs), .de(de), .skip(skip),
    .rgb(rgb), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .frame_start(frame_start), .line_start(line_start),
    .total_width(total_width), .total_height(total_height),
    .visible_width(visible_width), .visible_height(visible_height),
    .locked(locked), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int pv_cnt = 0, err_cnt = 0, consec = 0, rgb_bad = 0;
  int xmin = 9999, xmax = -1, ymin = 9999, ymax = -1;
  logic pv_prev = 1'b0;
  logic [31:0] s_locked, s_err, s_tw, s_th, s_vw, s_vh, s_fs, s_ls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, step past the edge, fold outputs into the frame statistics.
  task automatic cyc(input logic e, v, h, d, s, input int c, input int l);
    en = e; vs = v; hs = h; de = d; skip = s;
    rgb = {8'(c), 8'(l), 8'hA5};
    @(posedge clk);
    #1;
    if (pixel_valid) begin
      pv_cnt++;
      if (pv_prev) consec++;
      if (int'(pixel_x) < xmin) xmin = int'(pixel_x);
      if (int'(pixel_x) > xmax) xmax = int'(pixel_x);
      if (int'(pixel_y) < ymin) ymin = int'(pixel_y);
      if (int'(pixel_y) > ymax) ymax = int'(pixel_y);
      if (pixel_rgb.r != 8'(int'(pixel_x) + 5) || pixel_rgb.g != 8'(int'(pixel_y) + 2) ||
          pixel_rgb.b != 8'hA5) rgb_bad++;
    end
    pv_prev = pixel_valid;
    if (error) err_cnt++;
  endtask

  // Frame of h lines, 50 enabled cycles each (line bad_l is bad_len long),
  // active area columns 5..44 and lines 2..37; vs coincides with the first hs.
  task automatic frame(input int h, input bit half, input int bad_l, input int bad_len);
    int w;
    logic d;
    for (int l = 0; l < h; l++) begin
      w = (l == bad_l) ? bad_len : 50;
      for (int c = 0; c < w; c++) begin
        d = (l >= 2) && (l < 38) && (c >= 5) && (c < 45);
        cyc(1'b1, (l == 0) && (c == 0), c == 0, d, 1'b0, c, l);
        if (l == 0 && c == 0) begin
          s_locked = 32'(locked); s_err = 32'(error);
          s_tw = 32'(total_width); s_th = 32'(total_height);
          s_vw = 32'(visible_width); s_vh = 32'(visible_height);
          s_fs = 32'(frame_start); s_ls = 32'(line_start);
          pv_cnt = 0; err_cnt = 0; consec = 0; rgb_bad = 0;
          xmin = 9999; xmax = -1; ymin = 9999; ymax = -1;
        end
        if (half) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c, l);
      end
    end
  endtask

  initial begin
    rgb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pixel_valid", 32'(pixel_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_total_width", 32'(total_width), 0);
    chk("rst_error", 32'(error), 0);
    reset_n = 1'b1;
    repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("presync_line_start", 32'(line_start), 0);
    chk("presync_pixels", pv_cnt, 0);

    // full-rate enable, lock at the 4th vs
    frame(40, 1'b0, -1, 0);
    chk("f1_frame_start", s_fs, 1);
    chk("f1_line_start", s_ls, 1);
    chk("f1_locked", s_locked, 0);
    chk("f1_tw", s_tw, 0);
    chk("f1_pixels", pv_cnt, 1440);
    chk("f1_xmin", xmin, 0);
    chk("f1_xmax", xmax, 39);
    chk("f1_ymin", ymin, 0);
    chk("f1_ymax", ymax, 35);
    chk("f1_rgb", rgb_bad, 0);
    frame(40, 1'b0, -1, 0);
    chk("f2_tw", s_tw, 50);
    chk("f2_th", s_th, 40);
    chk("f2_vw", s_vw, 40);
    chk("f2_vh", s_vh, 36);
    chk("f2_locked", s_locked, 0);
    frame(40, 1'b0, -1, 0);
    chk("f3_locked", s_locked, 0);
    chk("f3_err", s_err, 0);
    frame(40, 1'b0, -1, 0);
    chk("f4_locked", s_locked, 1);
    chk("f4_err", s_err, 0);

    // asynchronous reset in the middle of an active line
    for (int c = 0; c < 120; c++)
      cyc(1'b1, c == 0, (c % 50) == 0, (c / 50 >= 2) && (c % 50 >= 5) && (c % 50 < 45),
          1'b0, c % 50, c / 50);
    chk("prerst_valid", 32'(pixel_valid), 1);
    chk("prerst_locked", 32'(locked), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(pixel_valid), 0);
    chk("arst_x", 32'(pixel_x), 0);
    chk("arst_rgb", 32'(pixel_rgb), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_tw", 32'(total_width), 0);
    chk("arst_th", 32'(total_height), 0);
    chk("arst_vw", 32'(visible_width), 0);
    chk("arst_vh", 32'(visible_height), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // half-rate enable, skip on idle cycles
    frame(40, 1'b1, -1, 0);
    chk("g1_locked", s_locked, 0);
    chk("g1_tw", s_tw, 0);
    chk("g1_pixels", pv_cnt, 1440);
    chk("g1_consec", consec, 0);
    frame(40, 1'b1, -1, 0);
    chk("g2_tw", s_tw, 50);
    chk("g2_th", s_th, 40);
    chk("g2_vw", s_vw, 40);
    chk("g2_vh", s_vh, 36);
    chk("g2_locked", s_locked, 0);
    chk("g2_consec", consec, 0);
    chk("g2_xmax", xmax, 39);
    chk("g2_rgb", rgb_bad, 0);
    frame(40, 1'b1, -1, 0);
    chk("g3_locked", s_locked, 0);
    frame(40, 1'b1, -1, 0);
    chk("g4_locked", s_locked, 1);

    // one short line after lock
    frame(40, 1'b0, 10, 49);
    chk("h1_locked", s_locked, 1);
    chk("h1_midframe_err", err_cnt, 0);
    frame(40, 1'b0, -1, 0);
    chk("h2_err", s_err, 1);
    chk("h2_locked", s_locked, 0);
    chk("h2_tw", s_tw, 50);
    frame(40, 1'b0, -1, 0);
    chk("h3_locked", s_locked, 0);
    chk("h3_err", s_err, 0);
    frame(40, 1'b0, -1, 0);
    chk("h4_locked", s_locked, 1);

    // 2000-cycle line saturates the column counter
    frame(40, 1'b0, 5, 2000);
    chk("sat_prev_locked", s_locked, 1);
    chk("sat_err_pulses", err_cnt, 1);
    chk("sat_locked", 32'(locked), 0);
    chk("sat_state", 32'(dut.state), 0);

    // height change: 30-line frames then back to 40
    frame(30, 1'b0, -1, 0);
    chk("a_err", s_err, 0);
    chk("a_locked", s_locked, 0);
    chk("a_pixels", pv_cnt, 1120);
    chk("a_ymax", ymax, 27);
    frame(30, 1'b0, -1, 0);
    chk("b_th", s_th, 30);
    chk("b_vh", s_vh, 28);
    chk("b_tw", s_tw, 50);
    chk("b_vw", s_vw, 40);
    chk("b_err", s_err, 0);
    frame(40, 1'b0, -1, 0);
    chk("c_err", s_err, 0);
    chk("c_locked", s_locked, 0);
    frame(40, 1'b0, -1, 0);
    chk("d_err", s_err, 1);
    chk("d_th", s_th, 40);
    chk("d_vh", s_vh, 36);
    chk("d_locked", s_locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
